// File: rtl/rgb_frame_scheduler_pkg.sv
// Shared types and helpers for the planar-RGB frame scheduler.
// Holds the FSM state encoding, a constant-evaluable clog2 and the default frame size.
package rgb_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_IMG_PIXELS = 1024;
    localparam int FRAME_BYTES    = 3 * DEF_IMG_PIXELS;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rgb_frame_scheduler_if.sv
// Byte-stream bundle between the sources, the scheduler and the downstream packer.
// master = source/packer side, slave = scheduler side.
interface rgb_frame_scheduler_if #(
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC-1:0]   s_tvalid;
    logic [NUM_SRC*8-1:0] s_tdata;
    logic [NUM_SRC-1:0]   s_tready;
    logic                 m_tvalid;
    logic [7:0]           m_tdata;
    logic                 m_tready;
    logic                 p_tvalid;
    logic                 p_tready;
    logic                 p_tlast;

    modport master (
        output s_tvalid, s_tdata, m_tready, p_tvalid, p_tready, p_tlast,
        input  s_tready, m_tvalid, m_tdata
    );

    modport slave (
        input  s_tvalid, s_tdata, m_tready, p_tvalid, p_tready, p_tlast,
        output s_tready, m_tvalid, m_tdata
    );
endinterface

// File: rtl/rgb_frame_scheduler_rr_arbiter.sv
// Combinational rotate-priority encoder: first requester strictly after 'last', circularly.
// When nobody requests, gnt_id echoes 'last' and any stays low.
module rr_arbiter
    import rgb_stream_pkg::*;
#(
    parameter  int N    = 2,
    localparam int IW   = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] gnt_id,
    output logic          any
);

    int            idx_s;
    logic [IW-1:0] cand_s;

    // Scan N positions starting one past the previous winner; the first hit wins.
    always_comb begin
        gnt_id = last;
        any    = 1'b0;
        idx_s  = 0;
        cand_s = '0;
        for (int k = 1; k <= N; k++) begin
            idx_s  = (int'(last) + k >= N) ? int'(last) + k - N : int'(last) + k;
            cand_s = IW'(idx_s);
            if (!any && req[cand_s]) begin
                gnt_id = cand_s;
                any    = 1'b1;
            end else begin
                any    = any;
            end
        end
    end

endmodule

// File: rtl/rgb_frame_scheduler.sv
// Whole-frame round-robin scheduler: one source owns the packer input for a full R/G/B frame
// and keeps it until the packer's tlast pixel handshakes downstream.
module rgb_frame_scheduler
    import rgb_stream_pkg::*;
#(
    parameter  int NUM_SRC    = 2,
    parameter  int IMG_PIXELS = 1024,
    parameter  int CNT_W      = 16,
    localparam int ID_W       = clog2(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    rgb_frame_scheduler_if.slave bus,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 frame_done,
    output logic [CNT_W-1:0]     frame_count,
    output logic                 seq_err
);

    localparam int              FRM_BYTES = 3 * IMG_PIXELS;
    localparam int              BC_W      = clog2(FRM_BYTES);
    localparam logic [BC_W-1:0] LAST_CNT  = BC_W'(FRM_BYTES - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ID_W-1:0]   grant_id_r;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [BC_W-1:0]   byte_cnt_r;
    logic [CNT_W-1:0]  frame_count_r;
    logic              frame_done_r;
    logic              seq_err_r;
    logic [ID_W-1:0]   arb_gnt_s;
    logic              arb_any_s;
    logic              grant_s;
    logic              last_beat_s;
    logic              beat_s;
    logic              tlast_hs_s;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .req    (bus.s_tvalid),
        .last   (rr_ptr_r),
        .gnt_id (arb_gnt_s),
        .any    (arb_any_s)
    );

    assign beat_s     = bus.m_tvalid & bus.m_tready;
    assign tlast_hs_s = bus.p_tvalid & bus.p_tready & bus.p_tlast;

    // Next-state decode: grant only from IDLE, leave XFER on the final byte, leave DRAIN on tlast.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        last_beat_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && arb_any_s) begin
                    grant_s     = 1'b1;
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (beat_s && (byte_cnt_r == LAST_CNT)) begin
                    last_beat_s = 1'b1;
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            ST_DRAIN: begin
                if (tlast_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Zero-latency stream mux; only the granted source can see ready, and only in XFER.
    always_comb begin
        bus.s_tready = '0;
        bus.m_tvalid = 1'b0;
        bus.m_tdata  = 8'h00;
        if (state_r == ST_XFER) begin
            bus.m_tvalid             = bus.s_tvalid[grant_id_r];
            bus.m_tdata              = bus.s_tdata[8*int'(grant_id_r) +: 8];
            bus.s_tready[grant_id_r] = bus.m_tready;
        end else begin
            bus.m_tdata = 8'h00;
        end
    end

    // State register, granted source and round-robin pointer (reset points at the last source).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            grant_id_r <= '0;
            rr_ptr_r   <= ID_W'(NUM_SRC - 1);
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                grant_id_r <= arb_gnt_s;
                rr_ptr_r   <= arb_gnt_s;
            end
        end
    end

    // Byte position within the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_r <= '0;
        end else if (last_beat_s) begin
            byte_cnt_r <= '0;
        end else if (beat_s) begin
            byte_cnt_r <= byte_cnt_r + BC_W'(1);
        end
    end

    // Frame completion pulse/counter and the sticky out-of-sequence tlast flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_r  <= 1'b0;
            frame_count_r <= '0;
            seq_err_r     <= 1'b0;
        end else begin
            frame_done_r <= (state_r == ST_DRAIN) && tlast_hs_s;
            if ((state_r == ST_DRAIN) && tlast_hs_s) begin
                frame_count_r <= frame_count_r + CNT_W'(1);
            end
            if ((state_r != ST_DRAIN) && tlast_hs_s) begin
                seq_err_r <= 1'b1;
            end
        end
    end

    assign grant_id    = grant_id_r;
    assign busy        = (state_r != ST_IDLE);
    assign frame_done  = frame_done_r;
    assign frame_count = frame_count_r;
    assign seq_err     = seq_err_r;

endmodule

// File: tb/tb_rgb_frame_scheduler.sv
// Directed bench for rgb_frame_scheduler with a behavioural planar-RGB packer downstream.
// Expected bytes and pixels are queued at load time and popped as handshakes occur.
module tb_rgb_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        grant_id;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        seq_err;

    rgb_frame_scheduler_if #(.NUM_SRC(2)) bus ();

    rgb_frame_scheduler #(.NUM_SRC(2), .IMG_PIXELS(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    // Packer model: gathers 12 bytes, then emits 4 registered pixels {R,G,B}, tlast on the 4th.
    logic [7:0]  pk_buf [0:11];
    logic [3:0]  pk_wr;
    logic [1:0]  pk_idx;
    logic        pk_emit;
    logic [23:0] pk_data;
    logic        inj;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_wr   <= 4'd0;
            pk_idx  <= 2'd0;
            pk_emit <= 1'b0;
        end else begin
            if (bus.m_tvalid && bus.m_tready) begin
                pk_buf[pk_wr] <= bus.m_tdata;
                if (pk_wr == 4'd11) begin
                    pk_wr   <= 4'd0;
                    pk_emit <= 1'b1;
                end else begin
                    pk_wr <= pk_wr + 4'd1;
                end
            end
            if (pk_emit && bus.p_tready) begin
                if (pk_idx == 2'd3) begin
                    pk_idx  <= 2'd0;
                    pk_emit <= 1'b0;
                end else begin
                    pk_idx <= pk_idx + 2'd1;
                end
            end
        end
    end

    assign pk_data      = {pk_buf[pk_idx], pk_buf[4'd4 + 4'(pk_idx)], pk_buf[4'd8 + 4'(pk_idx)]};
    assign bus.m_tready = !pk_emit && bus.p_tready;
    assign bus.p_tvalid = pk_emit | inj;
    assign bus.p_tlast  = (pk_emit && (pk_idx == 2'd3)) | inj;

    int          checks;
    int          errors;
    int          bytes_seen;
    logic [7:0]  src0_q [$];
    logic [7:0]  src1_q [$];
    logic [8:0]  exp_q  [$];
    logic [24:0] pix_q  [$];
    logic [15:0] exp_count;
    logic        exp_done;
    logic        exp_seq;
    logic        in_frame;
    logic [1:0]  hs_r;
    logic        bp_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        logic [7:0] d0;
        logic [7:0] d1;
        d0 = (src0_q.size() != 0) ? src0_q[0] : 8'h00;
        d1 = (src1_q.size() != 0) ? src1_q[0] : 8'h00;
        bus.s_tvalid = {src1_q.size() != 0, src0_q.size() != 0};
        bus.s_tdata  = {d1, d0};
    endtask

    task automatic load_frame(input logic src, input logic [7:0] first);
        logic [7:0] b;
        for (int k = 0; k < 12; k++) begin
            b = first + 8'(k);
            if (src) src1_q.push_back(b);
            else     src0_q.push_back(b);
            exp_q.push_back({src, b});
        end
        for (int k = 0; k < 4; k++) begin
            pix_q.push_back({k == 3, first + 8'(k), first + 8'(k + 4), first + 8'(k + 8)});
        end
    endtask

    // Called at the falling edge: everything is stable until the next rising edge.
    task automatic observe();
        logic [8:0]  e;
        logic [24:0] px;
        logic [1:0]  exp_hs;
        chk("frame_done", frame_done, exp_done);
        chk("frame_count", frame_count, exp_count);
        chk("seq_err", seq_err, exp_seq);
        exp_done = 1'b0;
        if (in_frame) chk("busy_in_frame", busy, 1'b1);
        if (!busy) begin
            chk("idle_s_tready", bus.s_tready, 2'b00);
            chk("idle_m_tvalid", bus.m_tvalid, 1'b0);
        end
        hs_r   = bus.s_tvalid & bus.s_tready;
        exp_hs = 2'b00;
        if (bus.m_tvalid && bus.m_tready) begin
            chk("byte_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e      = exp_q.pop_front();
                exp_hs = e[8] ? 2'b10 : 2'b01;
                chk("m_tdata", bus.m_tdata, e[7:0]);
                chk("grant_id", grant_id, e[8]);
                bytes_seen++;
                in_frame = 1'b1;
            end
        end
        chk("src_handshake", hs_r, exp_hs);
        if (bus.p_tvalid && bus.p_tready) begin
            if (inj) begin
                exp_seq = 1'b1;
            end else begin
                chk("pixel_expected", pix_q.size() > 0, 1'b1);
                if (pix_q.size() > 0) begin
                    px = pix_q.pop_front();
                    chk("pixel", {bus.p_tlast, pk_data}, px);
                    if (px[24]) begin
                        exp_done  = 1'b1;
                        exp_count = exp_count + 16'd1;
                        in_frame  = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        if (hs_r[0]) void'(src0_q.pop_front());
        if (hs_r[1]) void'(src1_q.pop_front());
        bus.p_tready = bp_mode ? ~bus.p_tready : 1'b1;
        drive_src();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 1'b0);
        chk("rst_frame_count", frame_count, 16'd0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_seq_err", seq_err, 1'b0);
        chk("rst_s_tready", bus.s_tready, 2'b00);
        chk("rst_m_tvalid", bus.m_tvalid, 1'b0);
        src0_q.delete(); src1_q.delete(); exp_q.delete(); pix_q.delete();
        exp_count  = 16'd0;
        exp_done   = 1'b0;
        exp_seq    = 1'b0;
        in_frame   = 1'b0;
        hs_r       = 2'b00;
        bytes_seen = 0;
        drive_src();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_frames(input logic [15:0] target, input int budget, input string tag);
        int n;
        n = 0;
        while (exp_count != target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, exp_count, target);
    endtask

    task automatic wait_bytes(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (bytes_seen < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, bytes_seen, target);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b1;
        enable  = 1'b1;
        inj     = 1'b0;
        bp_mode = 1'b0;
        bus.s_tvalid = 2'b00;
        bus.s_tdata  = 16'h0000;
        bus.p_tready = 1'b1;
        #2;
        apply_reset();

        // Single source, bytes 0x01..0x0C
        load_frame(1'b0, 8'h01);
        drive_src();
        wait_frames(16'd1, 200, "t1_timeout");
        tick();
        chk("t1_grant", grant_id, 1'b0);
        chk("t1_count", frame_count, 16'd1);

        // Contention from reset: 0,1,0,1
        apply_reset();
        load_frame(1'b0, 8'h10);
        load_frame(1'b1, 8'h20);
        load_frame(1'b0, 8'h30);
        load_frame(1'b1, 8'h40);
        drive_src();
        wait_frames(16'd4, 400, "t2_timeout");
        tick();
        chk("t2_count", frame_count, 16'd4);

        // Backpressure on both packer ports
        bp_mode = 1'b1;
        load_frame(1'b0, 8'h50);
        drive_src();
        wait_frames(16'd5, 400, "t3_timeout");
        bp_mode = 1'b0;
        tick();

        // Enable dropped on byte 5 of a src1 frame; pointer is at 0 so src1 goes first
        bytes_seen = 0;
        load_frame(1'b1, 8'h60);
        load_frame(1'b0, 8'h70);
        load_frame(1'b1, 8'h80);
        drive_src();
        wait_bytes(5, 100, "t4_bytes");
        enable = 1'b0;
        wait_frames(16'd6, 200, "t4_frame_timeout");
        repeat (6) begin
            tick();
            chk("t4_idle_busy", busy, 1'b0);
            chk("t4_grant_hold", grant_id, 1'b1);
        end
        enable = 1'b1;
        wait_frames(16'd8, 400, "t4_resume_timeout");

        // Reset after byte 7; afterwards source 0 wins despite pointer having been at 0
        bytes_seen = 0;
        load_frame(1'b0, 8'h90);
        drive_src();
        wait_bytes(7, 100, "t5_bytes");
        apply_reset();
        load_frame(1'b0, 8'hA0);
        load_frame(1'b1, 8'hB0);
        drive_src();
        wait_frames(16'd2, 300, "t5_timeout");

        // Spurious tlast handshake during XFER
        bytes_seen = 0;
        load_frame(1'b0, 8'hC0);
        drive_src();
        wait_bytes(5, 100, "t6_bytes");
        inj = 1'b1;
        tick();
        inj = 1'b0;
        wait_frames(16'd3, 300, "t6_timeout");
        tick();
        tick();
        chk("t6_seq_err_sticky", seq_err, 1'b1);
        chk("t6_count", frame_count, 16'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
